// File: rtl/param_ram_loader_if.sv
// Parameter-load bus between a host/DMA parameter stream and the loader.
// The master modport is the host side, the slave modport is the loader.
interface param_ram_loader_if #(
    parameter int BIT_WIDTH = 8,
    parameter int SIZE      = 26,
    parameter int CNT_W     = $clog2(SIZE + 1)
);
    logic                      load_start;
    logic                      wr_valid;
    logic [BIT_WIDTH-1:0]      wr_data;
    logic                      wr_ready;
    logic                      load_done;
    logic [CNT_W-1:0]          load_count;
    logic                      wr_err;
    logic                      read;
    logic [BIT_WIDTH*SIZE-1:0] read_out;

    modport master (
        output load_start, wr_valid, wr_data, read,
        input  wr_ready, load_done, load_count, wr_err, read_out
    );

    modport slave (
        input  load_start, wr_valid, wr_data, read,
        output wr_ready, load_done, load_count, wr_err, read_out
    );
endinterface

// File: rtl/param_ram_loader.sv
// Run-time loadable filter parameter store: accepts SIZE words in order over
// a valid/ready stream and presents the whole set as one registered wide word.
module param_ram_loader #(
    parameter int BIT_WIDTH = 8,
    parameter int SIZE      = 26,
    parameter int CNT_W     = $clog2(SIZE + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    param_ram_loader_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic [BIT_WIDTH-1:0]      mem_q [SIZE];
    logic [BIT_WIDTH-1:0]      mem_d [SIZE];
    logic [BIT_WIDTH*SIZE-1:0] rd_q, rd_d;

    // Handshake and status are decoded straight from registered state.
    assign bus.wr_ready   = (state_q == LOAD);
    assign bus.load_done  = (state_q == FULL);
    assign bus.load_count = cnt_q;
    assign bus.wr_err     = err_q;
    assign bus.read_out   = rd_q;

    // Next-state, write-path and read-capture logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        mem_d   = mem_q;
        rd_d    = rd_q;

        // Capture from mem_q, so a write in the same cycle shows its old value.
        if (bus.read) begin
            for (int i = 0; i < SIZE; i++) begin
                rd_d[i*BIT_WIDTH +: BIT_WIDTH] = mem_q[i];
            end
        end

        // load_start wins over any beat offered in the same cycle.
        if (bus.load_start) begin
            state_d = LOAD;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (bus.wr_valid) begin
                        for (int i = 0; i < SIZE; i++) begin
                            if (cnt_q == CNT_W'(i)) begin
                                mem_d[i] = bus.wr_data;
                            end
                        end
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(SIZE - 1)) begin
                            state_d = FULL;
                        end
                    end
                end
                default: begin
                    // Word offered while not loading: discard and flag.
                    if (bus.wr_valid) begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // State, counter, flag, array and read-port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rd_q    <= '0;
            // NOTE: the parameter array is reset on purpose; a cleared set must read back as zero.
            for (int i = 0; i < SIZE; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            for (int i = 0; i < SIZE; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_param_ram_loader.sv
// Self-checking bench for param_ram_loader: directed scenarios plus a random
// sequence, all checked against a word-array reference model.
module tb_param_ram_loader;

    localparam int W     = 8;
    localparam int SIZE  = 26;
    localparam int CNT_W = $clog2(SIZE + 1);

    logic clk;
    logic rst_n;

    param_ram_loader_if #(.BIT_WIDTH(W), .SIZE(SIZE)) bus ();

    param_ram_loader #(.BIT_WIDTH(W), .SIZE(SIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the stored words, how many words of the current load
    // have arrived, whether a load is open, whether a set is complete.
    logic [W-1:0]        m_words [SIZE];
    int                  m_count;
    bit                  m_loading;
    bit                  m_complete;
    bit                  m_err;
    logic [W*SIZE-1:0]   m_out;

    function automatic logic [W*SIZE-1:0] pack_words();
        logic [W*SIZE-1:0] p;
        for (int i = 0; i < SIZE; i++) p[i*W +: W] = m_words[i];
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SIZE; i++) m_words[i] = '0;
        m_count    = 0;
        m_loading  = 0;
        m_complete = 0;
        m_err      = 0;
        m_out      = '0;
    endtask

    task automatic model_cycle(input bit ls, input bit wv, input logic [W-1:0] d, input bit rd);
        if (rd) m_out = pack_words();
        if (ls) begin
            m_loading  = 1;
            m_complete = 0;
            m_count    = 0;
            m_err      = 0;
        end else if (m_loading && wv) begin
            m_words[m_count] = d;
            m_count++;
            if (m_count == SIZE) begin
                m_loading  = 0;
                m_complete = 1;
            end
        end else if (!m_loading && wv) begin
            m_err = 1;
        end
    endtask

    // Applies one cycle of stimulus, advances the model, returns #1 after the edge.
    task automatic drive(input bit ls, input bit wv, input logic [W-1:0] d, input bit rd);
        bus.load_start = ls;
        bus.wr_valid   = wv;
        bus.wr_data    = d;
        bus.read       = rd;
        model_cycle(ls, wv, d, rd);
        @(posedge clk);
        #1;
        bus.load_start = 1'b0;
        bus.wr_valid   = 1'b0;
        bus.read       = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.load_start = 1'b0;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.read       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(0, 0, 8'h00, 1);
        n_checks++;
        if (bus.read_out !== '0) begin
            n_fail++; $display("FAIL reset_read_out actual=%h required=0", bus.read_out);
        end
        n_checks++;
        if ({bus.wr_ready, bus.load_done, bus.wr_err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags actual=%b required=000", {bus.wr_ready, bus.load_done, bus.wr_err});
        end
        n_checks++;
        if (bus.load_count !== '0) begin
            n_fail++; $display("FAIL reset_count actual=%0d required=0", bus.load_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [W*SIZE-1:0] r;
        drive(1, 0, 8'h00, 0);
        for (int i = 0; i < SIZE; i++) begin
            n_checks++;
            if (bus.wr_ready !== 1'b1) begin
                n_fail++; $display("FAIL b2b_ready beat=%0d actual=%b required=1", i, bus.wr_ready);
            end
            drive(0, 1, W'(i + 1), 0);
        end
        n_checks++;
        if ({bus.load_done, bus.wr_ready} !== 2'b10) begin
            n_fail++; $display("FAIL b2b_done_ready actual=%b required=10", {bus.load_done, bus.wr_ready});
        end
        n_checks++;
        if (bus.load_count !== CNT_W'(SIZE)) begin
            n_fail++; $display("FAIL b2b_count actual=%0d required=%0d", bus.load_count, SIZE);
        end
        drive(0, 0, 8'h00, 1);
        r = bus.read_out;
        n_checks++;
        if (r[7:0] !== 8'h01 || r[207:200] !== 8'h1A) begin
            n_fail++; $display("FAIL b2b_ends actual=%h/%h required=01/1a", r[7:0], r[207:200]);
        end
        n_checks++;
        if (r !== m_out) begin
            n_fail++; $display("FAIL b2b_read_out actual=%h required=%h", r, m_out);
        end
    endtask

    task automatic test_bubbles();
        int k = 0;
        drive(1, 0, 8'h00, 0);
        while (k < SIZE) begin
            drive(0, 0, W'($urandom), 0);
            n_checks++;
            if (bus.load_count !== CNT_W'(k)) begin
                n_fail++; $display("FAIL bubble_count actual=%0d required=%0d", bus.load_count, k);
            end
            drive(0, 1, W'(k + 1), 0);
            k++;
        end
        drive(0, 0, 8'h00, 1);
        n_checks++;
        if (bus.read_out !== m_out || bus.load_count !== CNT_W'(SIZE)) begin
            n_fail++; $display("FAIL bubble_read_out actual=%h required=%h", bus.read_out, m_out);
        end
    endtask

    task automatic test_err_in_full();
        drive(0, 1, 8'hFF, 0);
        n_checks++;
        if (bus.wr_err !== 1'b1) begin
            n_fail++; $display("FAIL full_err actual=%b required=1", bus.wr_err);
        end
        drive(0, 0, 8'h00, 1);
        n_checks++;
        if (bus.read_out !== m_out) begin
            n_fail++; $display("FAIL full_unchanged actual=%h required=%h", bus.read_out, m_out);
        end
        drive(1, 0, 8'h00, 0);
        n_checks++;
        if ({bus.wr_err, bus.load_done, bus.wr_ready} !== 3'b001 || bus.load_count !== '0) begin
            n_fail++; $display("FAIL restart_clear actual=%b/%0d required=001/0",
                               {bus.wr_err, bus.load_done, bus.wr_ready}, bus.load_count);
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 10; i++) drive(0, 1, 8'hAA, 0);
        drive(1, 1, 8'h33, 0);
        n_checks++;
        if (bus.load_count !== '0 || bus.wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_count actual=%0d required=0", bus.load_count);
        end
        for (int i = 0; i < SIZE; i++) drive(0, 1, 8'h55, 0);
        drive(0, 0, 8'h00, 1);
        for (int i = 0; i < SIZE; i++) begin
            n_checks++;
            if (bus.read_out[i*W +: W] !== 8'h55) begin
                n_fail++; $display("FAIL abort_word idx=%0d actual=%h required=55", i, bus.read_out[i*W +: W]);
            end
        end
    endtask

    task automatic test_collision();
        drive(1, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, W'($urandom), 0);
        drive(0, 1, 8'h77, 1);
        n_checks++;
        if (bus.read_out[39:32] !== 8'h55) begin
            n_fail++; $display("FAIL collision_old actual=%h required=55", bus.read_out[39:32]);
        end
        drive(0, 0, 8'h00, 1);
        n_checks++;
        if (bus.read_out[39:32] !== 8'h77 || bus.read_out !== m_out) begin
            n_fail++; $display("FAIL collision_new actual=%h required=77", bus.read_out[39:32]);
        end
        // Asynchronous reset in the middle of a cycle while loading.
        drive(0, 1, 8'h12, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (bus.read_out !== '0 || bus.load_count !== '0 ||
            {bus.wr_ready, bus.load_done, bus.wr_err} !== 3'b000) begin
            n_fail++; $display("FAIL async_reset actual=%h/%0d/%b required=0/0/000",
                               bus.read_out, bus.load_count, {bus.wr_ready, bus.load_done, bus.wr_err});
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(0, 0, 8'h00, 1);
        n_checks++;
        if (bus.read_out !== '0) begin
            n_fail++; $display("FAIL reset_array_cleared actual=%h required=0", bus.read_out);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
                  W'($urandom), $urandom_range(0, 3) == 0);
            n_checks++;
            if (bus.wr_ready !== m_loading || bus.load_done !== m_complete || bus.wr_err !== m_err) begin
                n_fail++; $display("FAIL rand_flags cyc=%0d actual=%b required=%b", c,
                                   {bus.wr_ready, bus.load_done, bus.wr_err}, {m_loading, m_complete, m_err});
            end
            n_checks++;
            if (bus.load_count !== CNT_W'(m_count)) begin
                n_fail++; $display("FAIL rand_count cyc=%0d actual=%0d required=%0d", c, bus.load_count, m_count);
            end
            n_checks++;
            if (bus.read_out !== m_out) begin
                n_fail++; $display("FAIL rand_read_out cyc=%0d actual=%h required=%h", c, bus.read_out, m_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_bubbles();
        test_err_in_full();
        test_abort();
        test_collision();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_ram_loader.md
Name: param_ram_loader

Overview:
- Writer-side counterpart of the kernel parameter ROM.
- Accepts one filter's parameters (5x5 weights + 1 bias by default) as a serial word stream over a valid/ready handshake. Stores them in an internal register array.
- Presents the whole parameter set as one wide word on a registered read port, so weights can be reloaded at run time instead of fixed at elaboration.
- Sits between the host/DMA parameter stream and a convolution layer.

Parameters:
- BIT_WIDTH, 8, width of one weight/bias word.
- SIZE, 26, number of words per parameter set (5x5 filter + 1 bias).
- CNT_W, $clog2(SIZE+1), width of the word counter (derived; do not override).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_start  input  1  single-cycle pulse; begins (or restarts) loading a parameter set.
- wr_valid  input  1  wr_data holds a valid word.
- wr_data  input  BIT_WIDTH  parameter word; words arrive in order: index 0 first, bias (index SIZE-1) last.
- wr_ready  output  1  loader accepts a word this cycle.
- load_done  output  1  a complete set of SIZE words is stored.
- load_count  output  CNT_W  number of words accepted in the current load.
- wr_err  output  1  sticky flag: a word was offered while not loading.
- read  input  1  capture the stored set onto read_out.
- read_out  output  BIT_WIDTH*SIZE  word i occupies bits [i*BIT_WIDTH +: BIT_WIDTH].

Behaviour:
- Reset (async, rst_n=0) forces:
  - state IDLE, all array words 0;
  - read_out 0, load_count 0;
  - wr_ready, load_done and wr_err all 0.
- Release of reset is synchronous to clk.
- FSM states:
  - IDLE: wr_ready=0. load_start -> LOAD.
  - LOAD: wr_ready=1. A beat is accepted when wr_valid & wr_ready. It writes weights[load_count] <= wr_data and increments load_count. Accepting the beat with load_count==SIZE-1 moves to FULL; load_count then reads SIZE.
  - FULL: wr_ready=0, load_done=1. load_start -> LOAD.
- Entering LOAD from any state:
  - clears load_count, load_done and wr_err;
  - stored words are not cleared; they are overwritten as new beats arrive.
- wr_ready is a registered/state-decoded output. It is high in the first LOAD cycle after load_start and low in the cycle after the final beat is accepted.
- load_start while in LOAD aborts the current load:
  - load_count returns to 0 next cycle;
  - any wr_valid beat in that same cycle is not written.
- load_start has priority over a simultaneous beat in every state.
- wr_valid=1 in IDLE or FULL, without load_start that cycle, sets wr_err. The word is discarded. wr_err stays set until the next load_start or reset.
- Read port:
  - read=1 captures all SIZE array words into read_out at the next rising edge (1-cycle latency);
  - read=0 holds read_out.
  - read is honoured in every state, including mid-load; partially loaded sets are returned as-is.
- Read/write collision: if read and an accepted beat occur in the same cycle, read_out takes the array contents before that write (old value of the written word).
- A beat's new value is visible on read_out when read is asserted one or more cycles after that beat is accepted.
- No arithmetic beyond the counter. load_count never exceeds SIZE; there is no wrap-around.
- Reset mid-load returns to IDLE with array cleared. It is not required to finish the transaction.

Test Plan:
- Reset, then read=1 with no load -> read_out==0; wr_ready=0, load_done=0, wr_err=0.
- load_start, then 26 back-to-back beats 0x01..0x1A, then read -> load_done=1 the cycle after beat 26; load_count=26; read_out[7:0]=0x01 and read_out[207:200]=0x1A.
- Load with wr_valid toggling every other cycle (bubbles) -> only valid beats counted; final contents identical to the back-to-back case.
- In FULL, drive wr_valid=1 with 0xFF -> wr_err=1; array unchanged. Next load_start -> wr_err=0, load_done=0, load_count=0.
- Mid-load abort: load 10 words of 0xAA, pulse load_start with a concurrent beat, then load 26 words of 0x55 -> all 26 read words are 0x55; the concurrent beat is not counted.
- Collision: on the cycle beat 5 (index 4, 0x77) is accepted, assert read -> read_out[39:32] shows the old value; read again one cycle later -> 0x77. Assert rst_n=0 mid-load -> all outputs 0 immediately (asynchronous).
